// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 slave on the system clock with a one-entry reply holding register
// Oversamples SCLK/MOSI/SS_n, shifts MSB-first both ways, pulses rx_valid per received word.
module spi_slave_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  spi_SCLK,
  input  logic                  spi_MOSI,
  input  logic                  spi_SS_n,
  output logic                  spi_MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   ss_dly_q;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  rxsh_q, rxsh_d;
  logic [DATA_WIDTH-1:0]  txsh_q, txsh_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   rx_done_q, rx_done_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   miso_q, miso_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic sclk_en, load;

  // Oldest sample sits in the MSB of each chain.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_SS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_MOSI};
      sclk_dly_q  <= sclk_s;
      ss_dly_q    <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ss_fall   = ~ss_s & ss_dly_q;
  assign ss_rise   = ss_s & ~ss_dly_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rxsh_q      <= '0;
      txsh_q      <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rxsh_q      <= rxsh_d;
      txsh_q      <= txsh_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_done_q   <= rx_done_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rxsh_d      = rxsh_q;
    txsh_d      = txsh_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_done_d   = 1'b0;
    load        = 1'b0;
    // An SS_n edge in the same cycle as an SCLK edge takes priority.
    sclk_en     = (state_q == ST_ACTIVE) & ~ss_fall & ~ss_rise;

    if (ss_fall) begin
      state_d   = ST_ACTIVE;
      bit_cnt_d = '0;
      load      = 1'b1;
    end else if (ss_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (sclk_en && sclk_rise) begin
      rxsh_d = {rxsh_q[DATA_WIDTH-2:0], mosi_s};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        rx_data_d = rxsh_d;
        rx_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (sclk_en && sclk_fall) begin
      if (bit_cnt_q == '0) begin
        load = 1'b1;
      end else begin
        txsh_d = {txsh_q[DATA_WIDTH-2:0], 1'b0};
      end
    end

    // A load sees the register as it was before this cycle's write.
    if (load) begin
      txsh_d      = hold_full_q ? hold_q : '0;
      hold_full_d = 1'b0;
    end
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    underrun_d = load & ~hold_full_q;
    rx_valid_d = rx_done_q;
    miso_d     = (state_q == ST_ACTIVE) ? txsh_q[DATA_WIDTH-1] : 1'b0;
  end

  assign spi_MISO    = miso_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = (state_q == ST_ACTIVE);

endmodule
